// File: rtl/bank_rdseq.sv
// Strided burst read sequencer for a bank64k D-priority read port, with credit-managed output FIFO.
// Optional denied-request counter enabled by defining BANK_RDSEQ_STATS_EN.
module bank_rdseq #(
  parameter int W  = 128,
  parameter int A  = 9,
  parameter int FD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [A-1:0] cmd_base,
  input  logic [A-1:0] cmd_stride,
  input  logic [A-1:0] cmd_len,
  output logic         rd_csel,
  output logic         rd_en,
  output logic [A-1:0] rd_addr,
  input  logic [W-1:0] rd_word,
  input  logic         rd_grnt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_word,
  output logic         out_last,
  output logic         busy,
  output logic [15:0]  stall_cnt
);

  // state  | meaning
  // S_IDLE | waiting for a burst command, cmd_ready high
  // S_RUN  | issuing reads for the latched burst
  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam int CW = $clog2(FD + 1);
  localparam int PW = $clog2(FD);

  state_e         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [A-1:0]   stride_q, stride_d;
  logic [A-1:0]   remain_q, remain_d;
  logic           inflight_q, inflight_d;
  logic           infl_last_q, infl_last_d;
  logic [W-1:0]   mem_q [FD];
  logic [W-1:0]   mem_d [FD];
  logic [FD-1:0]  last_q, last_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [CW:0]    credit_sum;
  logic           grant;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // The credit check ignores a same-cycle pop, so a full FIFO never receives an extra push.
  assign credit_sum = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign rd_en      = (state_q == S_RUN) && (credit_sum < (CW+1)'(FD));
  assign rd_csel    = rd_en;
  assign rd_addr    = addr_q;
  assign cmd_ready  = (state_q == S_IDLE);
  assign grant      = rd_en & rd_grnt;
  assign push       = inflight_q;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign out_word   = mem_q[rd_ptr_q];
  assign out_last   = out_valid & last_q[rd_ptr_q];
  assign busy       = (state_q == S_RUN) | inflight_q | out_valid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remain_d    = remain_q;
    inflight_d  = grant;
    infl_last_d = infl_last_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_base;
          stride_d = cmd_stride;
          remain_d = cmd_len;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (grant) begin
          addr_d      = addr_q + stride_q;
          infl_last_d = (remain_q == '0);
          if (remain_q == '0) state_d = S_IDLE;
          else                remain_d = remain_q - A'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q]  = rd_word;
      last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Data storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef BANK_RDSEQ_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (rd_en && !rd_grnt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bank_rdseq.sv
// Directed bench for bank_rdseq: a bench-side bank model returns an address-derived word
// one cycle after each grant; popped words are compared against hand-derived address lists.
module tb_bank_rdseq;

  localparam int W  = 128;
  localparam int A  = 9;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [A-1:0] cmd_base;
  logic [A-1:0] cmd_stride;
  logic [A-1:0] cmd_len;
  logic         rd_csel;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_word;
  logic         rd_grnt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_last;
  logic         busy;
  logic [15:0]  stall_cnt;

  bank_rdseq #(.W(W), .A(A), .FD(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_len    (cmd_len),
    .rd_csel    (rd_csel),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_word    (rd_word),
    .rd_grnt    (rd_grnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_last   (out_last),
    .busy       (busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int grants  = 0;
  int g0;

  logic [W-1:0] rx_word [$];
  logic         rx_last [$];
  int           exp_addr [$];
  logic         exp_last [$];

  function automatic logic [W-1:0] bank(input int a);
    logic [31:0] av;
    av = 32'(a);
    return {av * 32'h9E3779B1, av ^ 32'hA5A5A5A5, av + 32'h0000_1000, av};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: record grant/pop just before the edge, then model the bank's return data.
  task automatic tick();
    logic         g;
    logic [A-1:0] ga;
    #1;
    g  = rd_en & rd_grnt;
    ga = rd_addr;
    if (g) grants++;
    if (out_valid && out_ready) begin
      rx_word.push_back(out_word);
      rx_last.push_back(out_last);
    end
    @(posedge clk);
    @(negedge clk);
    rd_word = g ? bank(int'(ga)) : '0;
  endtask

  task automatic issue(input int base, input int stride, input int len);
    cmd_base   = A'(base);
    cmd_stride = A'(stride);
    cmd_len    = A'(len);
    cmd_valid  = 1'b1;
    chk("cmd_ready_at_issue", 128'(cmd_ready), 128'(1));
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic expect_burst(input int base, input int stride, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_addr.push_back((base + i * stride) % 512);
      exp_last.push_back(i == len);
    end
  endtask

  task automatic drain(input string tag, input int n);
    int cyc;
    out_ready = 1'b1;
    rd_grnt   = 1'b1;
    cyc = 0;
    while (rx_word.size() < n && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_drain_count"}, 128'(rx_word.size()), 128'(n));
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_rx_size"}, 128'(rx_word.size()), 128'(exp_addr.size()));
    n = (rx_word.size() < exp_addr.size()) ? rx_word.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", tag, i), rx_word[i], bank(exp_addr[i]));
      chk($sformatf("%s_last%0d", tag, i), 128'(rx_last[i]), 128'(exp_last[i]));
    end
    rx_word.delete();
    rx_last.delete();
    exp_addr.delete();
    exp_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_stall;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_stride = '0;
    cmd_len    = '0;
    rd_word    = '0;
    rd_grnt    = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_rd_en",     128'(rd_en),     128'(0));
    chk("rst_rd_csel",   128'(rd_csel),   128'(0));
    chk("rst_rd_addr",   128'(rd_addr),   128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last",  128'(out_last),  128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));

    // Basic burst 5,7,9,11 with first output two cycles after the first grant
    issue(5, 2, 3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_rd_en%0d", i),   128'(rd_en),     128'(1));
      chk($sformatf("basic_addr%0d", i),    128'(rd_addr),   128'(5 + 2 * i));
      chk($sformatf("basic_cready%0d", i),  128'(cmd_ready), 128'(0));
      chk($sformatf("basic_ovalid%0d", i),  128'(out_valid), 128'(i >= 2));
      tick();
    end
    chk("basic_cmd_ready_after", 128'(cmd_ready), 128'(1));
    chk("basic_rd_en_after",     128'(rd_en),     128'(0));
    expect_burst(5, 2, 3);
    drain("basic", 4);
    check_rx("basic");
    tick();
    chk("basic_busy_end", 128'(busy), 128'(0));

    // Address wrap 510,511,0,1
    issue(510, 1, 3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_addr%0d", i), 128'(rd_addr), 128'((510 + i) % 512));
      tick();
    end
    expect_burst(510, 1, 3);
    drain("wrap", 4);
    check_rx("wrap");

    // Grant withheld for three cycles on address 7
    issue(3, 4, 2);
    chk("deny_addr_first", 128'(rd_addr), 128'(3));
    tick();
    rd_grnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("deny_hold_addr%0d", i), 128'(rd_addr), 128'(7));
      chk($sformatf("deny_hold_en%0d", i),   128'(rd_en),   128'(1));
      tick();
    end
    rd_grnt = 1'b1;
    chk("deny_addr_retry", 128'(rd_addr), 128'(7));
    tick();
    chk("deny_addr_last", 128'(rd_addr), 128'(11));
    tick();
    chk("deny_cmd_ready", 128'(cmd_ready), 128'(1));
`ifdef BANK_RDSEQ_STATS_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    chk("deny_stall_cnt", 128'(stall_cnt), 128'(exp_stall));
    expect_burst(3, 4, 2);
    drain("deny", 3);
    check_rx("deny");

    // Backpressure: credits allow exactly FD grants, then one grant per pop
    out_ready = 1'b0;
    issue(20, 1, 9);
    g0 = grants;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_grants_full", 128'(grants - g0), 128'(4));
    chk("bp_rd_en_full",  128'(rd_en),       128'(0));
    chk("bp_out_valid",   128'(out_valid),   128'(1));
    for (int p = 0; p < 2; p++) begin
      g0 = grants;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk($sformatf("bp_pop_grant%0d", p), 128'(grants - g0), 128'(1));
    end
    expect_burst(20, 1, 9);
    drain("bp", 10);
    check_rx("bp");
    tick();
    chk("bp_busy_end", 128'(busy), 128'(0));

    // Reset for one cycle right after a grant drops the returning word
    issue(100, 1, 5);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_out_valid", 128'(out_valid), 128'(0));
    chk("mrst_rd_en",     128'(rd_en),     128'(0));
    chk("mrst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("mrst_busy",      128'(busy),      128'(0));
    tick();
    tick();
    chk("mrst_out_valid_later", 128'(out_valid), 128'(0));
    chk("mrst_rx_empty",        128'(rx_word.size()), 128'(0));
    rx_word.delete();
    rx_last.delete();

    // Back-to-back: second command accepted while the first burst is still buffered
    out_ready = 1'b0;
    issue(40, 3, 2);
    tick();
    tick();
    tick();
    chk("b2b_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("b2b_buffered",  128'(out_valid), 128'(1));
    issue(200, 5, 1);
    for (int i = 0; i < 4; i++) tick();
    expect_burst(40, 3, 2);
    expect_burst(200, 5, 1);
    drain("b2b", 5);
    check_rx("b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
